// File: rtl/tx_uart.sv
// tx_uart: 8N1 serial transmitter with start/ready handshake.
// Define TX_UART_PARITY_EN for 8E1 framing (even parity bit after DATA).
module tx_uart #(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_tx,
  input  logic [7:0] data_tx,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       out_serial_tx,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TX_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam logic [15:0] LP_TC    = 16'(CLKS_PER_BIT - 1);
  localparam logic        LP_SLAST = 1'(STOP_BITS - 1);

  state_t      r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_idx;
  logic        r_stop;
  logic [7:0]  r_shift;
  logic        r_line;
  logic        r_ready;
  logic        r_done;
`ifdef TX_UART_PARITY_EN
  logic        r_par;
`endif

  logic w_tick;
  assign w_tick = (r_baud == LP_TC);

  always_ff @(posedge clk or negedge rst_tx) begin
    if (!rst_tx) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_line  <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
`ifdef TX_UART_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE || w_tick)
        r_baud <= '0;
      else
        r_baud <= r_baud + 16'd1;

      unique case (r_state)
        S_IDLE: begin
          if (tx_start) begin
            r_state <= S_START;
            r_shift <= data_tx;
            r_line  <= 1'b0;
            r_ready <= 1'b0;
`ifdef TX_UART_PARITY_EN
            r_par   <= ^data_tx;
`endif
          end
        end
        S_START: begin
          if (w_tick) begin
            r_state <= S_DATA;
            r_idx   <= '0;
            r_line  <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_idx == 3'd7) begin
`ifdef TX_UART_PARITY_EN
              r_state <= S_PARITY;
              r_line  <= r_par;
`else
              r_state <= S_STOP;
              r_line  <= 1'b1;
              r_stop  <= 1'b0;
`endif
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_line  <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
        end
`ifdef TX_UART_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_state <= S_STOP;
            r_line  <= 1'b1;
            r_stop  <= 1'b0;
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            if (r_stop == LP_SLAST) begin
              r_done <= 1'b1;
              // A request on the final edge chains the next frame with no gap.
              if (tx_start) begin
                r_state <= S_START;
                r_shift <= data_tx;
                r_line  <= 1'b0;
                r_ready <= 1'b0;
`ifdef TX_UART_PARITY_EN
                r_par   <= ^data_tx;
`endif
              end else begin
                r_state <= S_IDLE;
                r_line  <= 1'b1;
                r_ready <= 1'b1;
              end
            end else begin
              r_stop <= r_stop + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_line  <= 1'b1;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign out_serial_tx = r_line;
  assign tx_ready      = r_ready;
  assign tx_done       = r_done;

endmodule

// File: tb/tb_tx_uart.sv
// tb_tx_uart: directed checks of tx_uart framing, timing and reset.
// Two instances: A (1 clk/bit, 1 stop) and B (4 clk/bit, 2 stop).
module tb_tx_uart;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_tx;
  logic [7:0] data_a, data_b;
  logic       start_a, start_b;
  logic       ready_a, line_a, done_a;
  logic       ready_b, line_b, done_b;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef TX_UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  tx_uart #(.CLKS_PER_BIT(1), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_tx(rst_tx), .data_tx(data_a),
    .tx_start(start_a), .tx_ready(ready_a),
    .out_serial_tx(line_a), .tx_done(done_a)
  );

  tx_uart #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_b (
    .clk(clk), .rst_tx(rst_tx), .data_tx(data_b),
    .tx_start(start_b), .tx_ready(ready_b),
    .out_serial_tx(line_b), .tx_done(done_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Expected line level for frame bit slot b.
  function automatic logic ebit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PB == 1 && b == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic accept(input bit sel, input logic [7:0] d);
    @(negedge clk);
    if (sel) begin data_b = d; start_b = 1'b1; end
    else     begin data_a = d; start_a = 1'b1; end
    @(posedge clk);
  endtask

  // Walk one frame starting right after its accept edge.
  task automatic frame(input bit sel, input logic [7:0] d,
                       input int cpb, input int sb,
                       input bit skip, input bit hold,
                       input logic [7:0] nxt);
    int nb;
    bit first, last;
    nb = 9 + PB + sb;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < cpb; c++) begin
        first = skip && b == 0 && c == 0;
        last  = (b == nb - 1) && (c == cpb - 1);
        if (!first) @(negedge clk);
        check($sformatf("line[%0d.%0d]", b, c),
              sel ? line_b : line_a, ebit(d, b));
        check("ready_busy", sel ? ready_b : ready_a, 0);
        check("done_busy", sel ? done_b : done_a, first);
        if (sel) begin
          start_b = hold;
          data_b  = (hold && last) ? nxt : ~data_b;
        end else begin
          start_a = hold;
          data_a  = (hold && last) ? nxt : ~data_a;
        end
      end
    end
    @(negedge clk);
    check("done_end", sel ? done_b : done_a, 1);
    check("ready_end", sel ? ready_b : ready_a, !hold);
    check("line_end", sel ? line_b : line_a, !hold);
  endtask

  // Independent receiver: find start bit, sample 8 bits, check stop.
  task automatic rx_loop(input logic [7:0] d);
    logic [7:0] got;
    bit found;
    got   = '0;
    found = 1'b0;
    accept(0, d);
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (line_a === 1'b0) found = 1'b1;
    end
    check("rx_start", found, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got[i] = line_a;
    end
`ifdef TX_UART_PARITY_EN
    @(negedge clk);
    check("rx_par", line_a, ^d);
`endif
    @(negedge clk);
    check("rx_stop", line_a, 1);
    check("rx_byte", got, d);
    @(negedge clk);
    check("rx_done", done_a, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] bytes [3];
    rst_tx  = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    data_a  = '0;
    data_b  = '0;
    repeat (2) @(negedge clk);
    rst_tx = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_line_a", line_a, 1);
      check("idle_ready_a", ready_a, 1);
      check("idle_done_a", done_a, 0);
      check("idle_line_b", line_b, 1);
      check("idle_ready_b", ready_b, 1);
      check("idle_done_b", done_b, 0);
    end

    accept(0, 8'h96);
    frame(0, 8'h96, 1, 1, 0, 0, 8'h00);

    accept(1, 8'hA5);
    frame(1, 8'hA5, 4, 2, 0, 0, 8'h00);

    accept(0, 8'h55);
    frame(0, 8'h55, 1, 1, 0, 1, 8'h0F);
    frame(0, 8'h0F, 1, 1, 1, 0, 8'h00);

    accept(1, 8'h5A);
    frame(1, 8'h5A, 4, 2, 0, 1, 8'hC3);
    frame(1, 8'hC3, 4, 2, 1, 0, 8'h00);

    accept(0, 8'h00);
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    check("bit3_line", line_a, 0);
    check("bit3_ready", ready_a, 0);
    rst_tx = 1'b0;
    #1;
    check("arst_line", line_a, 1);
    check("arst_ready", ready_a, 1);
    check("arst_done", done_a, 0);
    @(negedge clk);
    check("rst_hold_line", line_a, 1);
    rst_tx = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_line", line_a, 1);
    check("post_rst_ready", ready_a, 1);
    accept(0, 8'h3C);
    frame(0, 8'h3C, 1, 1, 0, 0, 8'h00);

    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h96;
    foreach (bytes[i]) rx_loop(bytes[i]);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
